gte_mac_unit: RTL
=================

GTE_MAC_UNIT -- requirements
Module: gte_mac_unit

Interface
REQ-001 SHALL take parameter A_W, default 27, the signed multiplicand width.
REQ-002 SHALL take parameter B_W, default 18, the signed multiplier width.
REQ-003 SHALL take parameter ACC_W, default 48, the signed accumulator width; ACC_W >= A_W+B_W+2 and ACC_W > FLAG_W.
REQ-004 SHALL take parameter TERMS, default 3, the product terms per job (1..8).
REQ-005 SHALL take parameter FLAG_W, default 44, the signed range checked for overflow flags.
REQ-006 SHALL take parameter SHIFT, default 12, the arithmetic right shift applied when sf=1.
REQ-007 Ports SHALL be:
- clk  in  1  single clock; all logic rising-edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  job accepted when in_valid&in_ready.
- in_c  in  ACC_W  signed accumulator preload.
- in_a  in  TERMS*A_W  signed multiplicands, term i at [i*A_W +: A_W].
- in_b  in  TERMS*B_W  signed multipliers, term i at [i*B_W +: B_W].
- in_sub  in  TERMS  bit i=1 subtracts product i, else adds.
- in_sf  in  1  shift the result by SHIFT.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid&out_ready.
- out_acc  out  ACC_W  signed result.
- out_ovf_pos  out  1  sticky: some partial sum > 2^(FLAG_W-1)-1.
- out_ovf_neg  out  1  sticky: some partial sum < -2^(FLAG_W-1).

Function
REQ-008 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-009 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-010 On handshake in IDLE: register in_a/in_b/in_sub/in_sf; acc <= in_c; term counter <= 0; flags <= range check of in_c; state <= RUN.
REQ-011 Each RUN cycle: acc <= acc ± a[k]*b[k] (full-precision signed, sign-extended to ACC_W, no wrap); counter increments; after k = TERMS-1, state <= DONE.
REQ-012 After every RUN update, ovf_pos/ovf_neg SHALL OR in the range check of the new partial sum; flags clear only on the next job accept or reset.
REQ-013 Latency: handshake in cycle 0 -> out_valid first high in cycle TERMS+1, independent of data.
REQ-014 out_acc SHALL be acc >>> SHIFT (arithmetic) when the registered sf=1, else acc; flags use the unshifted sums.
REQ-015 In DONE, out_acc/flags SHALL hold stable while out_ready=0; on out handshake, state <= IDLE (new job accepted the following cycle at the earliest).
REQ-016 Input bus changes while not in IDLE SHALL not affect the job in flight.
REQ-017 TERMS=1 SHALL give one RUN cycle; the most-negative A_W x B_W product SHALL be exact.

Reset
REQ-018 resetn low SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, out_acc=0, flags=0, counter=0.
REQ-019 Reset asserted mid-RUN or in DONE SHALL discard the job with no output produced.

Structure
REQ-020 Shared package gte_pkg SHALL hold default width constants (A_W, B_W, ACC_W, FLAG_W, SHIFT) and the FSM state typedef.
REQ-021 One sub-module, gte_mac_dsp, SHALL implement the combinational c ± a*b step so it maps onto a single 27x18 DSP multiply-ALU; the FSM, counter and flags stay in gte_mac_unit.

Verification (TERMS=3, defaults)
REQ-022 c=0, a=(1,2,3), b=(4,5,6), sub=000, sf=0 -> out_acc=32 in cycle 4, flags 0.
REQ-023 Same operands, sub=010 -> out_acc=12; c=0x3000, sub=000, sf=1 -> out_acc=3 (0x3020>>>12).
REQ-024 c=2^43-1, a=(1,0,0), b=(1,0,0) -> out_acc=2^43, ovf_pos=1; c=-2^43, a0=1, b0=1, sub=001 -> ovf_neg=1; ovf_pos stays 1 when a later term returns the sum in range.
REQ-025 out_ready=0 for 5 cycles in DONE -> out_valid and out_acc stable, in_ready=0; release -> IDLE next cycle, second job accepted and correct.
REQ-026 resetn pulsed low in RUN cycle 2 -> out_valid never asserts for that job, all outputs 0; next job after reset completes with correct value.

Source files
------------

// File: rtl/gte_pkg.sv
// Shared constants and FSM state type for the GTE multiply-accumulate unit.
package gte_pkg;

    // Default operand / accumulator widths (one 27x18 DSP multiply-ALU).
    localparam int GTE_A_W    = 27;
    localparam int GTE_B_W    = 18;
    localparam int GTE_ACC_W  = 48;
    localparam int GTE_FLAG_W = 44;
    localparam int GTE_SHIFT  = 12;
    localparam int GTE_TERMS  = 3;

    // Job sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gte_state_e;

endpackage : gte_pkg

// File: rtl/gte_mac_dsp.sv
// Combinational c +/- a*b step, shaped for a single DSP multiply-ALU slice.
module gte_mac_dsp #(
    parameter int A_W   = 27,
    parameter int B_W   = 18,
    parameter int ACC_W = 48
) (
    input  logic signed [ACC_W-1:0] i_c,
    input  logic signed [A_W-1:0]   i_a,
    input  logic signed [B_W-1:0]   i_b,
    input  logic                    i_sub,
    output logic signed [ACC_W-1:0] o_r
);

    logic signed [A_W+B_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;

    // Full-precision signed product; the result width holds the most-negative
    // operand pair exactly.
    always_comb begin
        w_prod     = i_a * i_b;
        w_prod_ext = {{(ACC_W-A_W-B_W){w_prod[A_W+B_W-1]}}, w_prod};
    end

    // Post-adder: add or subtract the sign-extended product.
    always_comb begin
        if (i_sub) begin
            o_r = i_c - w_prod_ext;
        end else begin
            o_r = i_c + w_prod_ext;
        end
    end

endmodule : gte_mac_dsp

// File: rtl/gte_mac_unit.sv
// Multi-term signed multiply-accumulate: one product term per cycle on a
// shared DSP step, sticky range flags, optional arithmetic result shift.
module gte_mac_unit
    import gte_pkg::*;
#(
    parameter int A_W    = GTE_A_W,
    parameter int B_W    = GTE_B_W,
    parameter int ACC_W  = GTE_ACC_W,
    parameter int TERMS  = GTE_TERMS,
    parameter int FLAG_W = GTE_FLAG_W,
    parameter int SHIFT  = GTE_SHIFT
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ACC_W-1:0]       in_c,
    input  logic [TERMS*A_W-1:0]   in_a,
    input  logic [TERMS*B_W-1:0]   in_b,
    input  logic [TERMS-1:0]       in_sub,
    input  logic                   in_sf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_acc,
    output logic                   out_ovf_pos,
    output logic                   out_ovf_neg
);

    localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;

    // Flag thresholds 2^(FLAG_W-1)-1 and -2^(FLAG_W-1), sign-extended to ACC_W.
    localparam logic signed [ACC_W-1:0] FLAG_MAX =
        $signed({{(ACC_W-FLAG_W+1){1'b0}}, {(FLAG_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] FLAG_MIN =
        $signed({{(ACC_W-FLAG_W+1){1'b1}}, {(FLAG_W-1){1'b0}}});

    // Range check of an unshifted sum: {above max, below min}.
    function automatic logic [1:0] f_range(input logic signed [ACC_W-1:0] v);
        f_range = {(v > FLAG_MAX), (v < FLAG_MIN)};
    endfunction

    gte_state_e r_state;
    gte_state_e w_state_nxt;

    logic [A_W-1:0]          r_a [TERMS];
    logic [B_W-1:0]          r_b [TERMS];
    logic [TERMS-1:0]        r_sub;
    logic                    r_sf;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ovf_pos;
    logic                    r_ovf_neg;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [ACC_W-1:0]        r_out_acc;

    logic                    w_accept;
    logic                    w_step;
    logic                    w_last;
    logic signed [A_W-1:0]   w_a_sel;
    logic signed [B_W-1:0]   w_b_sel;
    logic                    w_sub_sel;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_result;
    logic [1:0]              w_sum_rng;
    logic [1:0]              w_c_rng;

    // Current term operands picked by the term counter.
    always_comb begin
        w_a_sel   = $signed(r_a[r_cnt]);
        w_b_sel   = $signed(r_b[r_cnt]);
        w_sub_sel = r_sub[r_cnt];
    end

    gte_mac_dsp #(
        .A_W   (A_W),
        .B_W   (B_W),
        .ACC_W (ACC_W)
    ) u_dsp (
        .i_c   (r_acc),
        .i_a   (w_a_sel),
        .i_b   (w_b_sel),
        .i_sub (w_sub_sel),
        .o_r   (w_sum)
    );

    // Range checks of the preload and of the new partial sum, plus the
    // presented result (shift applies only to the output, never the flags).
    always_comb begin
        w_sum_rng = f_range(w_sum);
        w_c_rng   = f_range($signed(in_c));
        if (r_sf) begin
            w_result = w_sum >>> SHIFT;
        end else begin
            w_result = w_sum;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_last      = (r_cnt == CNT_W'(TERMS-1));
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus registered handshake outputs decoded from next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Job capture, per-term accumulation, sticky flags and result register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TERMS; i++) begin
                r_a[i] <= {A_W{1'b0}};
                r_b[i] <= {B_W{1'b0}};
            end
            r_sub     <= {TERMS{1'b0}};
            r_sf      <= 1'b0;
            r_acc     <= {ACC_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_ovf_pos <= 1'b0;
            r_ovf_neg <= 1'b0;
            r_out_acc <= {ACC_W{1'b0}};
        end else if (w_accept) begin
            for (int i = 0; i < TERMS; i++) begin
                r_a[i] <= in_a[i*A_W +: A_W];
                r_b[i] <= in_b[i*B_W +: B_W];
            end
            r_sub     <= in_sub;
            r_sf      <= in_sf;
            r_acc     <= $signed(in_c);
            r_cnt     <= {CNT_W{1'b0}};
            r_ovf_pos <= w_c_rng[1];
            r_ovf_neg <= w_c_rng[0];
        end else if (w_step) begin
            r_acc     <= w_sum;
            r_ovf_pos <= r_ovf_pos | w_sum_rng[1];
            r_ovf_neg <= r_ovf_neg | w_sum_rng[0];
            if (w_last) begin
                r_cnt     <= {CNT_W{1'b0}};
                r_out_acc <= w_result;
            end else begin
                r_cnt     <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_acc     = r_out_acc;
    assign out_ovf_pos = r_ovf_pos;
    assign out_ovf_neg = r_ovf_neg;

endmodule : gte_mac_unit
